// File: rtl/latch_stage.sv
// Parametrised inter-stage pipeline latch: valid bit, flush, bubble insertion, held-cycle counter.
// Define LATCH_STAGE_STATS_EN to add the stat_stalls / stat_bubbles counters.
module latch_stage #(
  parameter int                 WIDTH       = 32,
  parameter logic [WIDTH-1:0]   BUBBLE      = '0,
  parameter int                 STALL_WIDTH = 6,
  parameter int                 STAGE       = 2,
  parameter int                 HOLD_WIDTH  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [STALL_WIDTH-1:0] stall,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [HOLD_WIDTH-1:0]  out_held,
`ifdef LATCH_STAGE_STATS_EN
  output logic [31:0]            stat_stalls,
  output logic [31:0]            stat_bubbles,
`endif
  output logic                   out_bubble
);

  if (STAGE < 0 || STAGE > STALL_WIDTH - 2) begin : g_bad_stage
    $error("latch_stage: STAGE must lie in 0..STALL_WIDTH-2");
  end

  logic up;
  logic dn;
  logic unused_stall_bits;

  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];
  // Only two bits of the stall vector matter here; the rest are deliberately ignored.
  assign unused_stall_bits = ^stall;

  logic                  vld_p1;
  logic [WIDTH-1:0]      data_p1;
  logic [HOLD_WIDTH-1:0] held_p1;
  logic                  bubble_p1;

  // ---- stage boundary: upstream -> latch register ----
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      vld_p1    <= 1'b0;
      data_p1   <= BUBBLE;
      held_p1   <= '0;
      bubble_p1 <= 1'b0;
    end else if (up && !dn) begin
      vld_p1    <= 1'b0;
      data_p1   <= BUBBLE;
      held_p1   <= '0;
      bubble_p1 <= 1'b1;
    end else if (!up) begin
      vld_p1    <= in_valid;
      data_p1   <= in_data;
      held_p1   <= '0;
      bubble_p1 <= 1'b0;
    end else if (held_p1 != {HOLD_WIDTH{1'b1}}) begin
      held_p1   <= held_p1 + 1'b1;
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign out_held   = held_p1;
  assign out_bubble = bubble_p1;

`ifdef LATCH_STAGE_STATS_EN
  logic [31:0] stalls_p1;
  logic [31:0] bubbles_p1;

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      stalls_p1  <= '0;
      bubbles_p1 <= '0;
    end else if (!flush) begin
      if (up && dn)  stalls_p1  <= stalls_p1 + 32'd1;
      if (up && !dn) bubbles_p1 <= bubbles_p1 + 32'd1;
    end
  end

  assign stat_stalls  = stalls_p1;
  assign stat_bubbles = bubbles_p1;
`endif

endmodule

// File: tb/tb_latch_stage.sv
// Scoreboard bench for latch_stage: driver queues expected results, monitor compares each cycle.
module tb_latch_stage;

  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_HOLD = 6'b001100;
  localparam logic [5:0] ST_BUB  = 6'b000100;
  localparam logic [5:0] ST_DN   = 6'b001000;
  localparam logic [5:0] ST_OTH  = 6'b110011;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;

  logic        out_valid,  out_valid3;
  logic [31:0] out_data,   out_data3;
  logic [7:0]  out_held;
  logic [2:0]  out_held3;
  logic        out_bubble, out_bubble3;
`ifdef LATCH_STAGE_STATS_EN
  logic [31:0] stat_stalls, stat_bubbles, stat_stalls3, stat_bubbles3;
`endif

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [7:0]  h;
    logic [2:0]  h3;
    logic        b;
    logic        chk_stats;
    logic [31:0] ss;
    logic [31:0] sb;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  logic        chk_stats = 1'b0;
  logic [31:0] exp_ss = '0;
  logic [31:0] exp_sb = '0;

  always #5 clock = ~clock;

  latch_stage #(.WIDTH(32), .BUBBLE(32'h0), .STALL_WIDTH(6), .STAGE(2), .HOLD_WIDTH(8)) u_dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_held(out_held),
`ifdef LATCH_STAGE_STATS_EN
    .stat_stalls(stat_stalls), .stat_bubbles(stat_bubbles),
`endif
    .out_bubble(out_bubble)
  );

  latch_stage #(.WIDTH(32), .BUBBLE(32'h0), .STALL_WIDTH(6), .STAGE(2), .HOLD_WIDTH(3)) u_dut3 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid3), .out_data(out_data3), .out_held(out_held3),
`ifdef LATCH_STAGE_STATS_EN
    .stat_stalls(stat_stalls3), .stat_bubbles(stat_bubbles3),
`endif
    .out_bubble(out_bubble3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("out_valid",  {31'd0, out_valid},  {31'd0, e.v});
      check("out_data",   out_data,            e.d);
      check("out_held",   {24'd0, out_held},   {24'd0, e.h});
      check("out_bubble", {31'd0, out_bubble}, {31'd0, e.b});
      check("out_valid3", {31'd0, out_valid3}, {31'd0, e.v});
      check("out_data3",  out_data3,           e.d);
      check("out_held3",  {29'd0, out_held3},  {29'd0, e.h3});
`ifdef LATCH_STAGE_STATS_EN
      if (e.chk_stats) begin
        check("stat_stalls",  stat_stalls,  e.ss);
        check("stat_bubbles", stat_bubbles, e.sb);
      end
`endif
    end
  end

  task automatic step(input logic r, input logic f, input logic [5:0] s,
                      input logic iv, input logic [31:0] id,
                      input logic ev, input logic [31:0] ed, input logic [7:0] eh, input logic eb);
    exp_t e;
    @(negedge clock);
    reset = r; flush = f; stall = s; in_valid = iv; in_data = id;
    e.v = ev; e.d = ed; e.h = eh; e.b = eb;
    e.h3 = (eh > 8'd7) ? 3'd7 : eh[2:0];
    e.chk_stats = chk_stats; e.ss = exp_ss; e.sb = exp_sb;
    sb_q.push_back(e);
  endtask

  initial begin
    // Reset with live-looking inputs.
    step(1, 0, ST_NONE, 1, 32'hDEADBEEF, 0, 32'h0, 0, 0);
    step(1, 0, ST_NONE, 1, 32'hDEADBEEF, 0, 32'h0, 0, 0);
    // Advance, including unrelated stall bits and downstream-only stall.
    step(0, 0, ST_NONE, 1, 32'h12345678, 1, 32'h12345678, 0, 0);
    step(0, 0, ST_NONE, 1, 32'h0000ABCD, 1, 32'h0000ABCD, 0, 0);
    step(0, 0, ST_OTH,  0, 32'h00000055, 0, 32'h00000055, 0, 0);
    step(0, 0, ST_DN,   1, 32'h00000011, 1, 32'h00000011, 0, 0);
    // Long hold: both counters saturate.
    for (int i = 1; i <= 260; i++)
      step(0, 0, ST_HOLD, 1, 32'h00000099, 1, 32'h00000011, (i > 255) ? 8'd255 : 8'(i), 0);
    // Bubble, hold on a bubble, then refill.
    step(0, 0, ST_NONE, 1, 32'h00000022, 1, 32'h00000022, 0, 0);
    step(0, 0, ST_BUB,  1, 32'h00000077, 0, 32'h0, 0, 1);
    step(0, 0, ST_HOLD, 1, 32'h00000078, 0, 32'h0, 1, 1);
    step(0, 0, ST_NONE, 1, 32'h00000033, 1, 32'h00000033, 0, 0);
    // Flush during hold and during a bubble request.
    step(0, 0, ST_NONE, 1, 32'h00000044, 1, 32'h00000044, 0, 0);
    step(0, 0, ST_HOLD, 1, 32'h00000045, 1, 32'h00000044, 1, 0);
    step(0, 0, ST_HOLD, 1, 32'h00000046, 1, 32'h00000044, 2, 0);
    step(0, 1, ST_HOLD, 1, 32'h00000047, 0, 32'h0, 0, 0);
    step(0, 0, ST_NONE, 1, 32'h00000044, 1, 32'h00000044, 0, 0);
    step(0, 1, ST_BUB,  1, 32'h00000048, 0, 32'h0, 0, 0);
    // Reset mid-hold, reset with flush, then hold straight after reset.
    step(0, 0, ST_NONE, 1, 32'h00000066, 1, 32'h00000066, 0, 0);
    step(0, 0, ST_HOLD, 1, 32'h00000067, 1, 32'h00000066, 1, 0);
    step(0, 0, ST_HOLD, 1, 32'h00000068, 1, 32'h00000066, 2, 0);
    step(1, 0, ST_HOLD, 1, 32'h00000069, 0, 32'h0, 0, 0);
    step(1, 1, ST_BUB,  1, 32'h0000006A, 0, 32'h0, 0, 0);
    step(0, 0, ST_HOLD, 1, 32'h0000006B, 0, 32'h0, 1, 0);
    // Statistics sequence.
    chk_stats = 1'b1; exp_ss = 0; exp_sb = 0;
    step(1, 0, ST_NONE, 1, 32'h00000001, 0, 32'h0, 0, 0);
    step(0, 0, ST_NONE, 1, 32'h00000010, 1, 32'h00000010, 0, 0);
    exp_ss = 1; step(0, 0, ST_HOLD, 1, 32'h00000011, 1, 32'h00000010, 1, 0);
    exp_ss = 2; step(0, 0, ST_HOLD, 1, 32'h00000012, 1, 32'h00000010, 2, 0);
    exp_ss = 3; step(0, 0, ST_HOLD, 1, 32'h00000013, 1, 32'h00000010, 3, 0);
    exp_sb = 1; step(0, 0, ST_BUB, 1, 32'h00000014, 0, 32'h0, 0, 1);
    exp_sb = 2; step(0, 0, ST_BUB, 1, 32'h00000015, 0, 32'h0, 0, 1);
    step(0, 1, ST_BUB,  1, 32'h00000016, 0, 32'h0, 0, 0);
    step(0, 1, ST_NONE, 1, 32'h00000017, 0, 32'h0, 0, 0);
    exp_ss = 4; step(0, 0, ST_HOLD, 1, 32'h00000018, 0, 32'h0, 1, 0);
    exp_ss = 0; exp_sb = 0; step(1, 0, ST_NONE, 1, 32'h00000019, 0, 32'h0, 0, 0);
    step(0, 0, ST_NONE, 0, 32'h0, 0, 32'h0, 0, 0);

    for (int n = 0; n < 10 && sb_q.size() > 0; n++) @(negedge clock);
    @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/latch_stage.md
Name: latch_stage

Overview:
- Generic parametrised inter-stage pipeline latch for the CPU pipeline. Generalises the fixed per-stage latches: payload width, stall-vector width and stage position are all parameters.
- Adds behaviour the fixed latches lack:
  - explicit valid bit;
  - synchronous flush for branch/exception squash;
  - a configurable bubble pattern;
  - a held-cycle counter.
- Sits between any two adjacent pipeline stages, driven by the central stall controller's stall vector.

Parameters:
- WIDTH, 32, payload width in bits (1..1024).
- BUBBLE, 0, payload value loaded on reset/flush/bubble (WIDTH bits, zero-extended).
- STALL_WIDTH, 6, width of the stall vector.
- STAGE, 2, index of upstream stage's stall bit; STAGE+1 is downstream bit; legal 0..STALL_WIDTH-2 (elaboration error otherwise).
- HOLD_WIDTH, 8, width of held-cycle counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- stall  input  STALL_WIDTH  stall vector from stall controller, bit=1 means stage stalled.
- flush  input  1  squash request, active-high, synchronous.
- in_valid  input  1  upstream payload is a real instruction.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  registered valid.
- out_data  output  WIDTH  registered payload.
- out_held  output  HOLD_WIDTH  consecutive cycles current contents have been held.
- out_bubble  output  1  contents are an inserted bubble (1 cycle after insertion until overwritten).

Behaviour:
- Define up = stall[STAGE], dn = stall[STAGE+1]. All updates on rising clock edge, one-cycle latency in→out.
- Priority per edge, highest first:
  1. reset: out_valid=0, out_data=BUBBLE, out_held=0, out_bubble=0.
  2. flush: out_valid=0, out_data=BUBBLE, out_held=0, out_bubble=0. Flush wins over any stall combination.
  3. bubble (up=1, dn=0): out_valid=0, out_data=BUBBLE, out_held=0, out_bubble=1.
  4. advance (up=0): out_valid=in_valid, out_data=in_data, out_held=0, out_bubble=0. dn is ignored here: a downstream stall always implies an upstream stall, so up=0/dn=1 is treated as advance.
  5. hold (up=1, dn=1): out_valid, out_data and out_bubble unchanged; out_held increments, saturating at 2^HOLD_WIDTH-1 (no wrap).
- out_data and out_valid update together in all cases; never one without the other.
- Bits of stall other than STAGE and STAGE+1 have no effect.
- in_valid=0 on advance still captures in_data verbatim; consumers must qualify on out_valid.
- Reset asserted mid-hold clears the counter immediately; the first edge after reset deasserts follows normal priority.
- Flush and reset together: identical result (reset path).

Optional Feature:
- Macro LATCH_STAGE_STATS_EN.
- Defined:
  - adds output stat_stalls [31:0], the total hold cycles since reset;
  - adds output stat_bubbles [31:0], the total bubble insertions since reset;
  - both wrap modulo 2^32 and clear on reset only (not flush);
  - flush and bubble in the same edge: flush wins, stat_bubbles does not increment.
- Undefined: ports absent, no counter logic; all other behaviour identical.

Test Plan:
- reset=1 two edges, stall=0, in_data=0xDEADBEEF, in_valid=1 → out_valid=0, out_data=BUBBLE (0), out_held=0, out_bubble=0.
- stall=0, in_valid=1, in_data=0x12345678 → next edge out_valid=1, out_data=0x12345678, out_held=0; new in_data 0x0000ABCD next edge → out_data=0x0000ABCD.
- Load 0x11, then stall=6'b001100 for 5 edges → out_data=0x11, out_valid=1, out_held=1,2,3,4,5. HOLD_WIDTH=3 with 10 edges → saturates at 7.
- Load 0x22, stall=6'b000100 one edge → out_valid=0, out_data=0, out_bubble=1; stall=0 next edge with in_data=0x33 → out_data=0x33, out_bubble=0.
- Load 0x44 during hold (stall=6'b001100), assert flush one edge → out_valid=0, out_data=0, out_held=0. Flush with simultaneous stall=6'b000100 → same result, out_bubble=0.
- With LATCH_STAGE_STATS_EN: 3 hold edges, 2 bubble edges, 1 flush+bubble edge → stat_stalls=3, stat_bubbles=2. Then flush → counters unchanged. Then reset → both 0.
